// File: rtl/trail_writer.sv
// trail_writer: paints each bike's head square into the frame buffer
// by read-modify-write, flags collisions, and wipes the buffer on request.
module trail_writer #(
  parameter int unsigned TRAIL_W    = 2,
  parameter logic [3:0]  BG_COLOR   = 4'h0,
  parameter logic [3:0]  BLUE_COLOR = 4'he,
  parameter logic [3:0]  RED_COLOR  = 4'h6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        clear,
  input  logic [9:0]  Blue_X,
  input  logic [9:0]  Blue_Y,
  input  logic [9:0]  Red_X,
  input  logic [9:0]  Red_Y,
  output logic [18:0] rd_address,
  input  logic [15:0] rd_data,
  output logic [18:0] write_address,
  output logic [15:0] wr_data,
  output logic        WE,
  output logic        is_blocked,
  output logic        is_blocked2,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, RD, WAIT, CHK, CLEAR
  } state_t;

  localparam logic [16:0] CLR_LAST = 17'd76799;
  localparam logic [2:0]  LAST_IDX = 3'(TRAIL_W - 1);

  state_t      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic [9:0]  bx_q, by_q, rx_q, ry_q;
  logic        red_q;
  logic [2:0]  i_q, j_q;
  logic [18:0] rd_addr_q;
  logic [16:0] clr_q;
  logic        blk_q, blk2_q;

  logic        frame_ev;
  logic [10:0] px, py;
  logic        offscr;
  logic [18:0] pix_addr;
  logic [3:0]  col, nib;
  logic [15:0] merged;
  logic        hit, last;

  assign frame_ev    = sync2_q & ~sync3_q;
  assign rd_address  = rd_addr_q;
  assign is_blocked  = blk_q;
  assign is_blocked2 = blk2_q;
  assign busy        = (state_q != IDLE);

  // Current pixel position, address and merged word for the active bike
  always_comb begin
    px = {1'b0, red_q ? rx_q : bx_q} + 11'(i_q);
    py = {1'b0, red_q ? ry_q : by_q} + 11'(j_q);
    offscr = (px > 11'd639) || (py > 11'd479);
    pix_addr = 19'(px[10:1]) + 19'(py) * 19'd320;
    col = red_q ? RED_COLOR : BLUE_COLOR;
    nib = px[0] ? rd_data[11:8] : rd_data[3:0];
    merged = px[0] ? {rd_data[15:12], col, rd_data[7:0]}
                   : {rd_data[15:4], col};
    hit = offscr || (nib != BG_COLOR);
    last = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  end

  // Write port: merged pixel in CHK, background words while clearing
  always_comb begin
    WE = 1'b0;
    write_address = '0;
    wr_data = '0;
    case (state_q)
      CHK: begin
        if (!hit) begin
          WE = 1'b1;
          write_address = rd_addr_q;
          wr_data = merged;
        end
      end
      CLEAR: begin
        WE = 1'b1;
        write_address = {2'b00, clr_q};
        wr_data = {4{BG_COLOR}};
      end
      default: ;
    endcase
  end

  // Frame-tick sync, per-pixel read/check sequencing and buffer wipe
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      bx_q <= '0;
      by_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
      red_q <= 1'b0;
      i_q <= '0;
      j_q <= '0;
      rd_addr_q <= '0;
      clr_q <= '0;
      blk_q <= 1'b0;
      blk2_q <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (clear && state_q != CLEAR) begin
        state_q <= CLEAR;
        clr_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (frame_ev) begin
              bx_q <= Blue_X;
              by_q <= Blue_Y;
              rx_q <= Red_X;
              ry_q <= Red_Y;
              i_q <= '0;
              j_q <= '0;
              if (!blk_q) begin
                red_q <= 1'b0;
                state_q <= RD;
              end else if (!blk2_q) begin
                red_q <= 1'b1;
                state_q <= RD;
              end
            end
          end
          RD: begin
            rd_addr_q <= pix_addr;
            state_q <= WAIT;
          end
          WAIT: state_q <= CHK;
          CHK: begin
            if (hit || last) begin
              if (hit) begin
                if (red_q) blk2_q <= 1'b1;
                else blk_q <= 1'b1;
              end
              i_q <= '0;
              j_q <= '0;
              if (!red_q && !blk2_q) begin
                red_q <= 1'b1;
                state_q <= RD;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              if (i_q == LAST_IDX) begin
                i_q <= '0;
                j_q <= j_q + 3'd1;
              end else begin
                i_q <= i_q + 3'd1;
              end
              state_q <= RD;
            end
          end
          CLEAR: begin
            clr_q <= clr_q + 17'd1;
            if (clr_q == CLR_LAST) begin
              blk_q <= 1'b0;
              blk2_q <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trail_writer.sv
// tb_trail_writer: frame buffer model plus write scoreboard
// driven by a reference painter for trail_writer.
module tb_trail_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        clear = 1'b0;
  logic [9:0]  Blue_X = '0, Blue_Y = '0, Red_X = '0, Red_Y = '0;
  logic [18:0] rd_address, write_address;
  logic [15:0] rd_data, wr_data;
  logic        WE, is_blocked, is_blocked2, busy;

  trail_writer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .clear(clear),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .rd_address(rd_address), .rd_data(rd_data),
    .write_address(write_address), .wr_data(wr_data), .WE(WE),
    .is_blocked(is_blocked), .is_blocked2(is_blocked2), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] mem [0:76799];
  logic [15:0] shadow [0:76799];
  logic [15:0] rd_q;
  logic        tb_wipe = 1'b0, tb_poke = 1'b0;
  logic [18:0] tb_addr = '0;
  logic [15:0] tb_dat = '0;
  assign rd_data = rd_q;

  always @(posedge Clk) begin
    if (tb_wipe) begin
      for (int k = 0; k < 76800; k++) mem[k] <= '0;
    end else if (tb_poke) begin
      mem[tb_addr] <= tb_dat;
    end else if (WE && write_address < 19'd76800) begin
      mem[write_address] <= wr_data;
    end
    rd_q <= (rd_address < 19'd76800) ? mem[rd_address] : 16'h0;
  end

  logic [34:0] exp_q[$];
  logic [34:0] mon_e;
  bit          mon_en = 1'b1;
  bit          mb = 1'b0, mr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en && WE) begin
      if (exp_q.size() == 0) begin
        chk("we_unexp", 64'(WE), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("we", {29'd0, write_address, wr_data}, {29'd0, mon_e});
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wipe();
    tb_wipe = 1'b1;
    step();
    tb_wipe = 1'b0;
    for (int k = 0; k < 76800; k++) shadow[k] = '0;
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    tb_poke = 1'b1;
    tb_addr = 19'(a);
    tb_dat = d;
    step();
    tb_poke = 1'b0;
    shadow[a] = d;
  endtask

  // Reference painter: pushes expected writes, returns busy cycles
  task automatic paint(input int bx, input int by, input int rx,
                       input int ry, output int cyc);
    int x, y, px, py, a;
    bit stop, fl;
    logic [15:0] w;
    logic [3:0] c, nb;
    Blue_X = 10'(bx); Blue_Y = 10'(by);
    Red_X = 10'(rx); Red_Y = 10'(ry);
    cyc = 0;
    for (int b = 0; b < 2; b++) begin
      fl = b ? mr : mb;
      if (!fl) begin
        x = b ? rx : bx;
        y = b ? ry : by;
        c = b ? 4'h6 : 4'he;
        stop = 0;
        for (int j = 0; j < 2; j++)
          for (int i = 0; i < 2; i++)
            if (!stop) begin
              cyc += 3;
              px = x + i;
              py = y + j;
              if (px > 639 || py > 479) stop = 1;
              else begin
                a = px / 2 + py * 320;
                w = shadow[a];
                nb = (px % 2) ? w[11:8] : w[3:0];
                if (nb != 4'h0) stop = 1;
                else begin
                  if (px % 2) w[11:8] = c;
                  else w[3:0] = c;
                  shadow[a] = w;
                  exp_q.push_back({19'(a), w});
                end
              end
            end
        if (stop) begin
          if (b) mr = 1'b1;
          else mb = 1'b1;
        end
      end
    end
  endtask

  task automatic run_frame(input string tag, input int exp_cyc,
                           input bit repulse);
    int n, cyc;
    n = 0;
    frame_clk = 1'b1;
    while (!busy && n < 10) begin step(); n++; end
    chk({tag, "_start"}, 64'(busy), 64'd1);
    frame_clk = 1'b0;
    cyc = 0;
    while (busy && cyc < 1000) begin
      step();
      cyc++;
      if (repulse && cyc == 8) frame_clk = 1'b1;
    end
    frame_clk = 1'b0;
    chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    repeat (12) step();
    chk({tag, "_q"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_blk"}, {62'd0, is_blocked, is_blocked2}, {62'd0, mb, mr});
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
    mb = 1'b0;
    mr = 1'b0;
  endtask

  initial begin
    int ec, n, cyc;
    logic [34:0] first;

    repeat (3) step();
    chk("rst_we", 64'(WE), 64'd0);
    chk("rst_rda", 64'(rd_address), 64'd0);
    chk("rst_wra", 64'(write_address), 64'd0);
    chk("rst_wd", 64'(wr_data), 64'd0);
    chk("rst_flags", {62'd0, is_blocked, is_blocked2}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    Reset = 1'b0;
    mb = 1'b0;
    mr = 1'b0;
    wipe();

    // basic paint of both squares
    paint(10, 20, 100, 50, ec);
    run_frame("basic", ec, 1'b0);
    chk("basic_cost", 64'(ec), 64'd24);
    chk("basic_word", 64'(mem[6405]), 64'h0e0e);
    chk("basic_red", 64'(mem[16370]), 64'h0606);

    // collision against a preloaded red pixel
    wipe();
    poke(6725, 16'h0600);
    paint(10, 20, 100, 50, ec);
    run_frame("coll", ec, 1'b0);
    chk("coll_flag", 64'(is_blocked), 64'd1);
    chk("coll_word", 64'(mem[6725]), 64'h060e);
    paint(10, 20, 100, 50, ec);
    run_frame("skip", ec, 1'b0);
    chk("skip_cost", 64'(ec), 64'd3);

    // reset in the middle of a wipe
    mon_en = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (50) step();
    chk("clr_we", 64'(WE), 64'd1);
    Reset = 1'b1;
    step();
    chk("mid_we", 64'(WE), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_flags", {62'd0, is_blocked, is_blocked2}, 64'd0);
    chk("mid_wra", 64'(write_address), 64'd0);
    chk("mid_rda", 64'(rd_address), 64'd0);
    do_reset();
    wipe();
    mon_en = 1'b1;

    // right-edge off-screen pixel
    paint(639, 0, 200, 300, ec);
    run_frame("edge", ec, 1'b0);
    chk("edge_cost", 64'(ec), 64'd18);
    chk("edge_flag", 64'(is_blocked), 64'd1);
    chk("edge_word", 64'(mem[319]), 64'h0e00);

    // tick re-pulsed while busy is dropped
    paint(300, 100, 400, 200, ec);
    run_frame("drop", ec, 1'b1);

    // clear issued on cycle 5 of a draw
    paint(5, 5, 500, 400, ec);
    first = exp_q[0];
    exp_q.delete();
    exp_q.push_back(first);
    for (int k = 0; k < 76800; k++) exp_q.push_back({19'(k), 16'h0});
    for (int k = 0; k < 76800; k++) shadow[k] = '0;
    mb = 1'b0;
    mr = 1'b0;
    n = 0;
    frame_clk = 1'b1;
    while (!busy && n < 10) begin step(); n++; end
    chk("clr_start", 64'(busy), 64'd1);
    frame_clk = 1'b0;
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    cyc = 5;
    while (busy && cyc < 80000) begin step(); cyc++; end
    chk("clr_cyc", 64'(cyc), 64'd76805);
    repeat (4) step();
    chk("clr_q", 64'(exp_q.size()), 64'd0);
    chk("clr_flags", {62'd0, is_blocked, is_blocked2}, 64'd0);
    paint(40, 60, 41, 61, ec);
    run_frame("after", ec, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
